// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues synchronous-read requests to the
// instruction memory, and buffers returned words in a small FIFO for decode.
module imem_fetch_sequencer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [31:0]           instr_pc,
    input  logic                  instr_ready,
    output logic                  busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [31:0] fetch_pc, fetch_pc_nxt;

    // Stage p0 is the issue cycle, stage p1 the cycle the memory returns data.
    logic        vld_p0;
    logic        vld_p1;
    logic [31:0] pc_p1;

    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [31:0]           fifo_pc   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        credit;
    logic                  push, pop;

    // Low two bits of a redirect target are not meaningful for word fetches.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = vld_p1 & ~redirect_valid;
    // Entries occupied or already promised after this cycle's pop.
    assign credit      = {1'b0, count} + (CNT_W + 1)'(vld_p1) - (CNT_W + 1)'(pop);

    assign mem_addr  = fetch_pc[ADDR_WIDTH+1:2];
    assign mem_rd_en = vld_p0;
    assign busy      = (state == RUN);
    assign instr     = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc  = instr_valid ? fifo_pc[rd_ptr]   : '0;

    // Next-state, next-PC and issue decision; redirect overrides everything.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        vld_p0       = 1'b0;
        if (redirect_valid) begin
            state_nxt    = RUN;
            fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt    = RUN;
                        fetch_pc_nxt = RESET_PC;
                    end
                end
                RUN: begin
                    if (!halt && (credit < (CNT_W + 1)'(DEPTH))) begin
                        vld_p0       = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, PC and in-flight flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            vld_p1   <= vld_p0;
        end
    end

    // p0 -> p1: remember which PC the outstanding read belongs to.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            pc_p1 <= fetch_pc;
        end
    end

    // FIFO pointers and occupancy; redirect flushes, push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // p1 -> FIFO: capture the returned word with its PC.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_pc[wr_ptr]   <= pc_p1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a 1-cycle-latency memory model.
module tb_imem_fetch_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          halt;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_data = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;
    logic          busy;

    logic [DW-1:0] imem [1024];

    int n_chk  = 0;
    int n_fail = 0;

    imem_fetch_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_data      (mem_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data <= imem[mem_addr];
        end
    end

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic h, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        start          = s;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = word(i);
        rst_n          = 1'b0;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        // Reset values
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        rst_n = 1'b1;

        // Start: no issue in the start cycle itself
        cyc(1, 0, 0, 0, 1);
        chk("start_busy", 32'(busy), 0);
        chk("start_rd_en", 32'(mem_rd_en), 0);

        // Streaming at one instruction per cycle; start at k==3 must be ignored
        for (int k = 0; k < 6; k++) begin
            cyc(k == 3, 0, 0, 0, 1);
            chk("run_busy", 32'(busy), 1);
            chk("run_rd_en", 32'(mem_rd_en), 1);
            chk("run_addr", 32'(mem_addr), 32'(k));
            if (k < 2) begin
                chk("run_valid_lat", 32'(instr_valid), 0);
            end else begin
                chk("run_valid", 32'(instr_valid), 1);
                chk("run_pc", instr_pc, 32'(4 * (k - 2)));
                chk("run_instr", instr, word(k - 2));
            end
        end

        // Backpressure: FIFO fills, issue stops
        for (int r = 0; r < 5; r++) begin
            cyc(0, 0, 0, 0, 0);
            chk("stall_rd_en", 32'(mem_rd_en), 0);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_pc", instr_pc, 32'h10);
        end

        // Resume without duplicate or lost PCs
        for (int t = 0; t < 4; t++) begin
            cyc(0, 0, 0, 0, 1);
            chk("resume_rd_en", 32'(mem_rd_en), 1);
            chk("resume_addr", 32'(mem_addr), 32'(6 + t));
            chk("resume_pc", instr_pc, 32'(16 + 4 * t));
            chk("resume_instr", instr, word(4 + t));
        end

        // Redirect to 0x40 with a read in flight and the FIFO occupied
        cyc(0, 0, 1, 32'h40, 0);
        chk("redir_rd_en", 32'(mem_rd_en), 0);
        cyc(0, 0, 0, 0, 1);
        chk("redir_valid1", 32'(instr_valid), 0);
        chk("redir_addr1", 32'(mem_addr), 16);
        chk("redir_rd_en1", 32'(mem_rd_en), 1);
        cyc(0, 0, 0, 0, 1);
        chk("redir_valid2", 32'(instr_valid), 0);
        chk("redir_addr2", 32'(mem_addr), 17);
        cyc(0, 0, 0, 0, 1);
        chk("redir_valid3", 32'(instr_valid), 1);
        chk("redir_pc3", instr_pc, 32'h40);
        chk("redir_instr3", instr, word(16));

        // Redirect with low bits set lands on 0x40
        cyc(0, 0, 1, 32'h43, 1);
        chk("redir43_rd_en", 32'(mem_rd_en), 0);
        cyc(0, 0, 0, 0, 1);
        chk("redir43_addr", 32'(mem_addr), 16);
        chk("redir43_valid1", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("redir43_valid2", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("redir43_valid3", 32'(instr_valid), 1);
        chk("redir43_pc", instr_pc, 32'h40);

        // Halt: buffered and in-flight words still delivered, no new issue
        cyc(0, 1, 0, 0, 1);
        chk("halt_rd_en0", 32'(mem_rd_en), 0);
        chk("halt_pc0", instr_pc, 32'h44);
        cyc(0, 1, 0, 0, 1);
        chk("halt_rd_en1", 32'(mem_rd_en), 0);
        chk("halt_pc1", instr_pc, 32'h48);
        cyc(0, 1, 0, 0, 1);
        chk("halt_valid2", 32'(instr_valid), 0);
        chk("halt_rd_en2", 32'(mem_rd_en), 0);
        cyc(0, 1, 0, 0, 1);
        chk("halt_valid3", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("unhalt_rd_en", 32'(mem_rd_en), 1);
        chk("unhalt_addr", 32'(mem_addr), 19);
        cyc(0, 0, 0, 0, 1);
        chk("unhalt_addr2", 32'(mem_addr), 20);
        cyc(0, 0, 0, 0, 1);
        chk("unhalt_valid", 32'(instr_valid), 1);
        chk("unhalt_pc", instr_pc, 32'h4C);
        chk("unhalt_instr", instr, word(19));

        // Address wrap at the top of the memory
        cyc(0, 0, 1, 32'hFFC, 1);
        chk("wrap_rd_en0", 32'(mem_rd_en), 0);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_addr1", 32'(mem_addr), 1023);
        chk("wrap_valid1", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_addr2", 32'(mem_addr), 0);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_pc3", instr_pc, 32'hFFC);
        chk("wrap_instr3", instr, word(1023));
        chk("wrap_addr3", 32'(mem_addr), 1);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_pc4", instr_pc, 32'h1000);
        chk("wrap_instr4", instr, word(0));

        // Reset mid-stream
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 1);
        chk("mrst_valid", 32'(instr_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_rd_en", 32'(mem_rd_en), 0);
        chk("mrst_instr", instr, 0);
        chk("mrst_pc", instr_pc, 0);
        chk("mrst_addr", 32'(mem_addr), 0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
